// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - shared types and codes for the LEGv8 multi-cycle control unit
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_B,
    CLS_CBZ,
    CLS_CBNZ,
    CLS_ADD,
    CLS_SUB,
    CLS_AND,
    CLS_ORR,
    CLS_ADDI,
    CLS_SUBI,
    CLS_ANDI,
    CLS_ORRI,
    CLS_LDUR,
    CLS_STUR
  } class_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  localparam logic [1:0] SEU_ALU = 2'b00;
  localparam logic [1:0] SEU_B   = 2'b01;
  localparam logic [1:0] SEU_CB  = 2'b10;
  localparam logic [1:0] SEU_D   = 2'b11;

  // opCode[10:5] groups; low bits select within a group where needed
  localparam logic [5:0] GRP_B      = 6'b000101;
  localparam logic [5:0] GRP_ADDAND = 6'b100010;
  localparam logic [5:0] GRP_IADDAND = 6'b100100;
  localparam logic [5:0] GRP_ORR    = 6'b101010;
  localparam logic [5:0] GRP_ORRI   = 6'b101100;
  localparam logic [5:0] GRP_CB     = 6'b101101;
  localparam logic [5:0] GRP_SUB    = 6'b110010;
  localparam logic [5:0] GRP_SUBI   = 6'b110100;
  localparam logic [5:0] GRP_MEM    = 6'b111110;

  function automatic logic [2:0] alu_code(class_e c);
    case (c)
      CLS_SUB, CLS_SUBI:  alu_code = ALU_SUB;
      CLS_AND, CLS_ANDI:  alu_code = ALU_AND;
      CLS_ORR, CLS_ORRI:  alu_code = ALU_ORR;
      CLS_CBZ, CLS_CBNZ:  alu_code = ALU_PASSB;
      default:            alu_code = ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] seu_code(class_e c);
    case (c)
      CLS_B:              seu_code = SEU_B;
      CLS_CBZ, CLS_CBNZ:  seu_code = SEU_CB;
      CLS_LDUR, CLS_STUR: seu_code = SEU_D;
      default:            seu_code = SEU_ALU;
    endcase
  endfunction

  function automatic logic uses_imm(class_e c);
    case (c)
      CLS_ADDI, CLS_SUBI, CLS_ANDI, CLS_ORRI, CLS_LDUR, CLS_STUR: uses_imm = 1'b1;
      default:                                                    uses_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/legv8_op_decode.sv
// rtl/legv8_op_decode.sv - combinational opCode to instruction-class decoder
module legv8_op_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] op_code,
  output class_e      cls
);

  // Bits 4, 2 and 0 never influence the class
  logic unused_bits;
  assign unused_bits = ^{op_code[4], op_code[2], op_code[0]};

  // Group on the top six bits, then split pairs on bit 3 or bit 1
  always_comb begin
    cls = CLS_ILLEGAL;
    case (op_code[10:5])
      GRP_B:       cls = CLS_B;
      GRP_ADDAND:  cls = op_code[3] ? CLS_ADD  : CLS_AND;
      GRP_IADDAND: cls = op_code[3] ? CLS_ADDI : CLS_ANDI;
      GRP_ORR:     cls = CLS_ORR;
      GRP_ORRI:    cls = CLS_ORRI;
      GRP_CB:      cls = op_code[3] ? CLS_CBNZ : CLS_CBZ;
      GRP_SUB:     cls = CLS_SUB;
      GRP_SUBI:    cls = CLS_SUBI;
      GRP_MEM:     cls = op_code[1] ? CLS_LDUR : CLS_STUR;
      default:     cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - multi-cycle LEGv8 control FSM with memory handshake and traps
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        opCode,
  input  logic               zero,
  input  logic               memAck,
  output logic               irWr,
  output logic               pcWr,
  output logic               pcSrc,
  output logic               iOrD,
  output logic               memRd,
  output logic               memWr,
  output logic               reg2Loc,
  output logic               regWr,
  output logic               aluSrc,
  output logic               memToReg,
  output logic [1:0]         seu,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               illegal,
  output logic               busErr
);

  // TIMEOUT = 0 disables the watchdog; keep the counter at least one bit wide
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  class_e           cls_q, cls_d;
  class_e           dec_cls;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             timed_out;

  legv8_op_decode u_decode (
    .op_code (opCode),
    .cls     (dec_cls)
  );

  // The current wait cycle is the last one allowed before a trap
  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // Next-state, class latch, memory wait counter and sticky trap flags
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        wait_d  = '0;
      end
      ST_FETCH: begin
        if (memAck) begin
          state_d = ST_DECODE;
        end else if (timed_out) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == CLS_ILLEGAL) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LDUR, CLS_STUR: begin
            state_d = ST_MEM;
            wait_d  = '0;
          end
          CLS_B, CLS_CBZ, CLS_CBNZ: begin
            state_d = ST_FETCH;
            wait_d  = '0;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (memAck) begin
          if (cls_q == CLS_LDUR) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            wait_d  = '0;
          end
        end else if (timed_out) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        wait_d  = '0;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset clears outputs at once because they decode from it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_ILLEGAL;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Moore decode of datapath controls; ALU setup is held from EXEC through WB
  always_comb begin
    irWr     = 1'b0;
    pcWr     = 1'b0;
    pcSrc    = 1'b0;
    iOrD     = 1'b0;
    memRd    = 1'b0;
    memWr    = 1'b0;
    reg2Loc  = 1'b0;
    regWr    = 1'b0;
    aluSrc   = 1'b0;
    memToReg = 1'b0;
    seu      = SEU_ALU;
    aluOp    = '0;
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      aluSrc = uses_imm(cls_q);
      seu    = seu_code(cls_q);
      aluOp  = ALUOP_W'(alu_code(cls_q));
    end
    case (state_q)
      ST_FETCH: begin
        memRd = 1'b1;
        irWr  = memAck;
        pcWr  = memAck;
      end
      ST_DECODE: begin
        // Register read happens here, before the class is latched
        reg2Loc = (dec_cls == CLS_CBZ) || (dec_cls == CLS_CBNZ) || (dec_cls == CLS_STUR);
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_B: begin
            pcWr  = 1'b1;
            pcSrc = 1'b1;
          end
          CLS_CBZ: begin
            pcWr  = zero;
            pcSrc = zero;
          end
          CLS_CBNZ: begin
            pcWr  = !zero;
            pcSrc = !zero;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        iOrD  = 1'b1;
        memRd = (cls_q == CLS_LDUR);
        memWr = (cls_q == CLS_STUR);
      end
      ST_WB: begin
        regWr    = 1'b1;
        memToReg = (cls_q == CLS_LDUR);
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign busErr  = bus_err_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb/tb_legv8_multicycle_ctrl.sv - randomized and directed bench for legv8_multicycle_ctrl
module tb_legv8_multicycle_ctrl;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg2loc;
    logic       reg_wr;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] seu;
    logic [2:0] alu_op;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  typedef struct packed {
    logic [2:0] kind;
    logic [2:0] alu;
  } info_t;

  localparam logic [2:0] K_ILL  = 3'd0;
  localparam logic [2:0] K_R    = 3'd1;
  localparam logic [2:0] K_I    = 3'd2;
  localparam logic [2:0] K_LD   = 3'd3;
  localparam logic [2:0] K_ST   = 3'd4;
  localparam logic [2:0] K_B    = 3'd5;
  localparam logic [2:0] K_CBZ  = 3'd6;
  localparam logic [2:0] K_CBNZ = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] opCode = '0;
  logic        zero = 1'b0;
  logic        memAck = 1'b0;
  logic        irWr, pcWr, pcSrc, iOrD, memRd, memWr;
  logic        reg2Loc, regWr, aluSrc, memToReg, illegal, busErr;
  logic [1:0]  seu;
  logic [2:0]  aluOp;
  ctl_t        obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] grps [9] = '{6'b000101, 6'b100010, 6'b100100, 6'b101010, 6'b101100,
                           6'b101101, 6'b110010, 6'b110100, 6'b111110};

  legv8_multicycle_ctrl #(.ALUOP_W(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .zero(zero), .memAck(memAck),
    .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc), .iOrD(iOrD), .memRd(memRd), .memWr(memWr),
    .reg2Loc(reg2Loc), .regWr(regWr), .aluSrc(aluSrc), .memToReg(memToReg),
    .seu(seu), .aluOp(aluOp), .illegal(illegal), .busErr(busErr)
  );

  always #5 clk = ~clk;

  assign obs = {irWr, pcWr, pcSrc, iOrD, memRd, memWr, reg2Loc, regWr,
                aluSrc, memToReg, seu, aluOp, illegal, busErr};

  // Instruction table from the ISA encoding rules
  function automatic info_t classify(logic [10:0] op);
    info_t r;
    r.alu  = 3'd0;
    r.kind = K_ILL;
    case (op[10:5])
      6'b000101: r.kind = K_B;
      6'b100010: begin r.kind = K_R; r.alu = op[3] ? 3'd0 : 3'd2; end
      6'b100100: begin r.kind = K_I; r.alu = op[3] ? 3'd0 : 3'd2; end
      6'b101010: begin r.kind = K_R; r.alu = 3'd3; end
      6'b101100: begin r.kind = K_I; r.alu = 3'd3; end
      6'b101101: begin r.kind = op[3] ? K_CBNZ : K_CBZ; r.alu = 3'd4; end
      6'b110010: begin r.kind = K_R; r.alu = 3'd1; end
      6'b110100: begin r.kind = K_I; r.alu = 3'd1; end
      6'b111110: r.kind = op[1] ? K_LD : K_ST;
      default:   r.kind = K_ILL;
    endcase
    return r;
  endfunction

  // ALU setup visible in EXEC, MEM and WB
  function automatic ctl_t held(info_t inf);
    ctl_t e = '0;
    e.alu_op  = inf.alu;
    e.alu_src = (inf.kind == K_I) || (inf.kind == K_LD) || (inf.kind == K_ST);
    case (inf.kind)
      K_B:          e.seu = 2'b01;
      K_CBZ, K_CBNZ: e.seu = 2'b10;
      K_LD, K_ST:   e.seu = 2'b11;
      default:      e.seu = 2'b00;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ack, input logic z, input ctl_t exp, input string tag);
    @(negedge clk);
    memAck = ack;
    zero   = z;
    #1;
    check(tag, exp);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    memAck = 1'b0;
    @(negedge clk);
    #1;
    check("reset_outputs", '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_after_release", '0);
  endtask

  // Whole instruction as the expected per-cycle control trace
  task automatic run_instr(input logic [10:0] op, input int fw, input int mw, input logic z);
    info_t inf = classify(op);
    ctl_t  e;
    opCode = op;
    for (int k = 0; k < fw; k++) begin
      e = '0; e.mem_rd = 1'b1;
      step(1'b0, 1'($urandom), e, "fetch_wait");
    end
    e = '0; e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    step(1'b1, 1'($urandom), e, "fetch_ack");
    e = '0;
    e.reg2loc = (inf.kind == K_CBZ) || (inf.kind == K_CBNZ) || (inf.kind == K_ST);
    step(1'($urandom), 1'($urandom), e, "decode");
    if (inf.kind == K_ILL) return;
    e = held(inf);
    if (inf.kind == K_B)    begin e.pc_wr = 1'b1; e.pc_src = 1'b1; end
    if (inf.kind == K_CBZ)  begin e.pc_wr = z;    e.pc_src = z;    end
    if (inf.kind == K_CBNZ) begin e.pc_wr = !z;   e.pc_src = !z;   end
    step(1'($urandom), z, e, "exec");
    if (inf.kind == K_LD || inf.kind == K_ST) begin
      e = held(inf); e.i_or_d = 1'b1;
      e.mem_rd = (inf.kind == K_LD); e.mem_wr = (inf.kind == K_ST);
      for (int k = 0; k < mw; k++) step(1'b0, 1'($urandom), e, "mem_wait");
      step(1'b1, 1'($urandom), e, "mem_ack");
    end
    if (inf.kind == K_R || inf.kind == K_I || inf.kind == K_LD) begin
      e = held(inf); e.reg_wr = 1'b1; e.mem_to_reg = (inf.kind == K_LD);
      step(1'($urandom), 1'($urandom), e, "wb");
    end
  endtask

  initial begin
    ctl_t e;
    int   fw, mw;
    logic [10:0] op;

    do_reset();

    // Directed: ADD, LDUR with one MEM wait, CBZ/CBNZ both zero values, STUR, B
    run_instr(11'b10001011000, 0, 0, 1'b0);
    run_instr(11'b11111000010, 0, 1, 1'b0);
    run_instr(11'b10110100000, 0, 0, 1'b1);
    run_instr(11'b10110100000, 0, 0, 1'b0);
    run_instr(11'b10110101000, 0, 0, 1'b1);
    run_instr(11'b10110101000, 0, 0, 1'b0);
    run_instr(11'b11111000000, 0, 0, 1'b0);
    run_instr(11'b00010100000, 0, 0, 1'b0);
    // Ack on the last permitted wait cycle in both FETCH and MEM
    run_instr(11'b11111000010, 3, 3, 1'b0);

    // Random legal instructions with random memory latency within the timeout
    for (int n = 0; n < 300; n++) begin
      op = {grps[$urandom_range(0, 8)], 5'($urandom)};
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr(op, fw, mw, 1'($urandom));
    end

    // Reset asserted during STUR MEM while memWr is high
    opCode = 11'b11111000000;
    e = '0; e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    step(1'b1, 1'b0, e, "stur_fetch");
    e = '0; e.reg2loc = 1'b1;
    step(1'b0, 1'b0, e, "stur_decode");
    e = held(classify(opCode));
    step(1'b0, 1'b0, e, "stur_exec");
    e.i_or_d = 1'b1; e.mem_wr = 1'b1;
    step(1'b0, 1'b0, e, "stur_mem");
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_in_mem", '0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(11'b10001011000, 0, 0, 1'b0);

    // FETCH timeout: four cycles with no ack, then bus error trap
    for (int k = 0; k < 4; k++) begin
      e = '0; e.mem_rd = 1'b1;
      step(1'b0, 1'($urandom), e, "fetch_timeout_wait");
    end
    for (int k = 0; k < 3; k++) begin
      e = '0; e.bus_err = 1'b1;
      step(1'($urandom), 1'($urandom), e, "fetch_timeout_trap");
    end
    do_reset();

    // MEM timeout on LDUR
    run_instr(11'b10001011000, 0, 0, 1'b0);
    opCode = 11'b11111000010;
    e = '0; e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    step(1'b1, 1'b0, e, "ld_fetch");
    step(1'b0, 1'b0, '0, "ld_decode");
    e = held(classify(opCode));
    step(1'b0, 1'b0, e, "ld_exec");
    e.i_or_d = 1'b1; e.mem_rd = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, e, "mem_timeout_wait");
    e = '0; e.bus_err = 1'b1;
    step(1'b1, 1'b0, e, "mem_timeout_trap");
    do_reset();

    // Undefined opcode traps after DECODE and stays quiet
    run_instr(11'b00000000000, 0, 0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      e = '0; e.illegal = 1'b1;
      step(1'($urandom), 1'($urandom), e, "illegal_trap");
    end
    do_reset();
    run_instr(11'b11001011000, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
